// File: rtl/dmem_readout_scheduler.sv
// dmem_readout_scheduler
// Arbitrates the single data-memory port between the core and a readout
// scanner. The core always wins; the scanner fetches one table word only
// in cycles with no core load/store, shows it on the display outputs for
// a fixed number of cycles, then moves to the next entry.

module dmem_readout_scheduler #(
   parameter int unsigned BASE_ADDR   = 2,
   parameter int unsigned COUNT       = 18,
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned MAX_STALL   = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        core_mem_read,
   input  logic        core_mem_write,
   input  logic [31:0] core_addr,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic [15:0] result,
   output logic        result_valid,
   output logic [15:0] result_index,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [15:0] stall_cnt
);

   // Hold counter only ever holds HOLD_CYCLES-1 down to 0.
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   // Consecutive-stall counter must be able to reach MAX_STALL.
   localparam int SW = $clog2(MAX_STALL + 1);

   localparam logic [31:0]   BASE       = 32'(BASE_ADDR);
   localparam logic [15:0]   LAST_INDEX = 16'(COUNT - 1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] STALL_MAX  = SW'(MAX_STALL);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_reg,        state_next;
   logic [31:0]     scan_addr_reg,    scan_addr_next;
   logic [15:0]     index_reg,        index_next;
   logic [HW-1:0]   hold_cnt_reg,     hold_cnt_next;
   logic [SW-1:0]   consec_reg,       consec_next;
   logic [15:0]     stall_cnt_reg,    stall_cnt_next;
   logic [15:0]     result_reg,       result_next;
   logic [15:0]     result_index_reg, result_index_next;
   logic            result_valid_reg, result_valid_next;
   logic            timeout_reg,      timeout_next;

   logic            core_active;
   logic [SW-1:0]   consec_inc;
   logic            unused_rdata_hi;

   // Only the low half of a table word is displayed.
   assign unused_rdata_hi = ^mem_rdata[31:16];

   assign core_active = core_mem_read | core_mem_write;
   assign consec_inc  = consec_reg + SW'(1);

   // Port mux: the core owns the address whenever it touches memory.
   assign mem_addr = core_active ? core_addr : scan_addr_reg;
   assign mem_we   = core_mem_write;

   assign result       = result_reg;
   assign result_valid = result_valid_reg;
   assign result_index = result_index_reg;
   assign stall_cnt    = stall_cnt_reg;
   assign timeout      = timeout_reg;
   assign busy         = (state_reg == SCAN) || (state_reg == HOLD);
   assign done         = (state_reg == DONE);

   // State and datapath registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         scan_addr_reg    <= BASE;
         index_reg        <= '0;
         hold_cnt_reg     <= '0;
         consec_reg       <= '0;
         stall_cnt_reg    <= '0;
         result_reg       <= '0;
         result_index_reg <= '0;
         result_valid_reg <= 1'b0;
         timeout_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         scan_addr_reg    <= scan_addr_next;
         index_reg        <= index_next;
         hold_cnt_reg     <= hold_cnt_next;
         consec_reg       <= consec_next;
         stall_cnt_reg    <= stall_cnt_next;
         result_reg       <= result_next;
         result_index_reg <= result_index_next;
         result_valid_reg <= result_valid_next;
         timeout_reg      <= timeout_next;
      end
   end

   // Next-state and datapath update; abort overrides everything else.
   always_comb begin
      state_next        = state_reg;
      scan_addr_next    = scan_addr_reg;
      index_next        = index_reg;
      hold_cnt_next     = hold_cnt_reg;
      consec_next       = consec_reg;
      stall_cnt_next    = stall_cnt_reg;
      result_next       = result_reg;
      result_index_next = result_index_reg;
      result_valid_next = 1'b0;
      timeout_next      = timeout_reg;

      if (abort) begin
         // Display, index and stall statistics stay visible after abort.
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  state_next     = SCAN;
                  scan_addr_next = BASE;
                  index_next     = '0;
                  hold_cnt_next  = '0;
                  consec_next    = '0;
                  stall_cnt_next = '0;
                  timeout_next   = 1'b0;
               end
            end

            SCAN: begin
               if (!core_active) begin
                  // Free slot: memory is addressed by scan_addr this cycle.
                  result_next       = mem_rdata[15:0];
                  result_index_next = index_reg;
                  result_valid_next = 1'b1;
                  consec_next       = '0;
                  hold_cnt_next     = HOLD_LOAD;
                  state_next        = HOLD;
               end else begin
                  if (stall_cnt_reg != 16'hFFFF) begin
                     stall_cnt_next = stall_cnt_reg + 16'd1;
                  end
                  consec_next = consec_inc;
                  if (consec_inc == STALL_MAX) begin
                     timeout_next = 1'b1;
                     state_next   = DONE;
                  end
               end
            end

            HOLD: begin
               if (hold_cnt_reg != '0) begin
                  hold_cnt_next = hold_cnt_reg - HW'(1);
               end else if (index_reg == LAST_INDEX) begin
                  state_next = DONE;
               end else begin
                  index_next     = index_reg + 16'd1;
                  scan_addr_next = scan_addr_reg + 32'd1;
                  state_next     = SCAN;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dmem_readout_scheduler.md
Name: dmem_readout_scheduler

Overview:
- Shares the single data-memory port between the single-cycle core and a readout scanner.
- The scanner walks the Fibonacci table stored in data memory and presents each word on a 16-bit display output.
- The core cannot stall, so the scanner steals only cycles in which the core makes no load/store. The core always has absolute priority.
- Sits between the core's load/store signals and the DataMemory port, replacing the direct ALU-result-to-address connection.

Parameters:
- BASE_ADDR, 2: word address of the first table entry.
- COUNT, 18: number of entries scanned; legal range 1..65535.
- HOLD_CYCLES, 4: cycles each captured value is held before the next fetch; legal minimum 1.
- MAX_STALL, 256: consecutive denied cycles in SCAN before the scan aborts with a timeout; legal minimum 1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE or DONE.
- abort  in  1  cancel the scan; takes effect from any state.
- core_mem_read  in  1  core is executing a load this cycle.
- core_mem_write  in  1  core is executing a store this cycle.
- core_addr  in  32  core data address (ALU result).
- mem_addr  out  32  address driven to DataMemory.
- mem_we  out  1  write enable to DataMemory.
- mem_rdata  in  32  DataMemory combinational read data.
- result  out  16  displayed value.
- result_valid  out  1  one-cycle pulse when result is updated.
- result_index  out  16  table index of the displayed value.
- busy  out  1  high in SCAN or HOLD.
- done  out  1  high in DONE.
- timeout  out  1  sticky; set on stall timeout.
- stall_cnt  out  16  total denied cycles in the current scan; saturates at 0xFFFF.

Behaviour:
- core_active = core_mem_read | core_mem_write.
- mem_addr = core_active ? core_addr : scan_addr. mem_we = core_mem_write, passed through combinationally.
- The scheduler never writes memory itself.
- Reset values: result=0, result_valid=0, result_index=0, busy=0, done=0, timeout=0, stall_cnt=0, scan_addr=BASE_ADDR, state=IDLE, internal counters 0.
- IDLE: on start, go to SCAN. Load scan_addr=BASE_ADDR, index=0, stall_cnt=0, consecutive-stall counter=0, timeout=0.
- SCAN, !core_active (granted slot):
  - same posedge captures result<=mem_rdata[15:0], result_index<=index, result_valid<=1, consecutive-stall counter<=0;
  - hold counter<=HOLD_CYCLES-1; go to HOLD.
  - Latency from SCAN entry to result_valid is 1 cycle when uncontended.
- SCAN, core_active (denied):
  - stay in SCAN; stall_cnt increments, saturating; consecutive-stall counter increments;
  - when the consecutive count reaches MAX_STALL, set timeout=1 and go to DONE without capturing.
- HOLD:
  - if the hold counter is nonzero, decrement it;
  - at zero: if index==COUNT-1, go to DONE; otherwise index++, scan_addr++ (32-bit wrap), go to SCAN.
  - Core accesses during HOLD pass through and are not counted as stalls.
- DONE: done=1, result is held. start restarts exactly as from IDLE. Otherwise remain in DONE.
- abort in any state: next state IDLE, busy=0, done=0.
  - result, result_index and timeout are retained; stall_cnt is retained until the next start.
  - abort has priority over start and over a simultaneous grant (no capture that cycle).
- start while busy is ignored.
- result_valid is high for exactly one cycle per captured entry, so exactly COUNT pulses per uncontended scan.
- rst mid-scan returns every output to its reset value on the next posedge.
- Memory contents are not affected by rst.

Test Plan:
- Preload mem[2..5]=0,1,1,2 with COUNT=4, HOLD_CYCLES=2, core idle; pulse start.
  - Required: result_valid pulses at 3-cycle spacing with results 0,1,1,2 and indices 0..3.
  - Required: done rises 2 cycles after the last pulse; stall_cnt=0.
- Same setup, with core_mem_write=1 and core_addr=9 asserted for 5 cycles right after start.
  - Required: mem_addr=9 and mem_we=1 during those cycles; first capture is delayed by 5 cycles; stall_cnt=5; captured values unchanged.
- With MAX_STALL=8, hold core_mem_read=1 continuously after start.
  - Required: after 8 cycles, timeout=1, done=1, no result_valid pulse, stall_cnt=8.
- Assert abort on the same cycle as a granted SCAN slot at index 2.
  - Required: no capture; next state IDLE; result still shows the index-1 value; busy=0.
- Pulse start while in HOLD: ignored.
  - Required: after DONE, a new start restarts at index 0; assert rst mid-scan and check all outputs return to 0 the next cycle.
